// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, widths, FSM states and result formatting for calc_sequencer
package calc_pkg;

   localparam int OPND_W     = 6;
   localparam int CALC_RES_W = 12;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // Only subtraction is signed; every other result is an unsigned magnitude.
   function automatic logic [CALC_RES_W-1:0] sel_result(
      input op_e         op,
      input logic [6:0]  add,
      input logic [6:0]  sub,
      input logic [11:0] mul,
      input logic [5:0]  div
   );
      logic [CALC_RES_W-1:0] res;
      case (op)
         OP_ADD:  res = {5'b0, add};
         OP_SUB:  res = {{5{sub[6]}}, sub};
         OP_MUL:  res = mul;
         default: res = {6'b0, div};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - link between the sequencer and the shared combinational calculator
interface calc_sequencer_if;
   logic [5:0]  data1;
   logic [5:0]  data2;
   logic [6:0]  add;
   logic [6:0]  sub;
   logic [11:0] mul;
   logic [5:0]  div;

   modport master (output data1, data2, input add, sub, mul, div);
   modport slave  (input data1, data2, output add, sub, mul, div);
endinterface

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin arbiter, combinational grant, pointer moves on accept
module rr_arbiter_2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_grant
);

   // r_last holds the index of the requester served most recently.
   logic r_last;

   always_comb begin
      o_grant = i_req;
      if (i_req == 2'b11)
         o_grant = r_last ? 2'b01 : 2'b10;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_last <= 1'b1;
      else if (i_accept)
         r_last <= o_grant[1];
   end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - shares one calculator between two requesters; optional DIV_ZERO_CHECK_EN
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 1,
   parameter int unsigned RES_W      = 12
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req0_valid,
   output logic                 o_req0_ready,
   input  logic [1:0]           i_req0_op,
   input  logic [OPND_W-1:0]    i_req0_a,
   input  logic [OPND_W-1:0]    i_req0_b,
   input  logic                 i_req1_valid,
   output logic                 o_req1_ready,
   input  logic [1:0]           i_req1_op,
   input  logic [OPND_W-1:0]    i_req1_a,
   input  logic [OPND_W-1:0]    i_req1_b,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic                 o_rsp_id,
   output logic [RES_W-1:0]     o_rsp_data,
   output logic                 o_rsp_err,
   calc_sequencer_if.master     calc
);

   state_e              r_state;
   logic [3:0]          r_cnt;
   op_e                 r_op;
   logic                r_id;
   logic [OPND_W-1:0]   r_data1;
   logic [OPND_W-1:0]   r_data2;
   logic                r_rsp_valid;
   logic                r_rsp_id;
   logic [RES_W-1:0]    r_rsp_data;
   logic                r_rsp_err;

   logic [1:0]          w_grant;
   logic                w_idle;
   logic                w_accept;
   op_e                 w_op;
   logic [OPND_W-1:0]   w_a;
   logic [OPND_W-1:0]   w_b;
   logic                w_div_zero;

   rr_arbiter_2 u_arb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_req    ({i_req1_valid, i_req0_valid}),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   // Ready is gated by reset so nothing shows as accepted while the block is held.
   assign w_idle       = (r_state == ST_IDLE) & ~i_rst;
   assign o_req0_ready = w_idle & w_grant[0];
   assign o_req1_ready = w_idle & w_grant[1];
   assign w_accept     = (i_req0_valid & o_req0_ready) | (i_req1_valid & o_req1_ready);

   assign w_op = w_grant[1] ? op_e'(i_req1_op) : op_e'(i_req0_op);
   assign w_a  = w_grant[1] ? i_req1_a : i_req0_a;
   assign w_b  = w_grant[1] ? i_req1_b : i_req0_b;

`ifdef DIV_ZERO_CHECK_EN
   assign w_div_zero = (w_op == OP_DIV) && (w_b == '0);
`else
   assign w_div_zero = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_op        <= OP_ADD;
         r_id        <= 1'b0;
         r_data1     <= '0;
         r_data2     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op    <= w_op;
                  r_id    <= w_grant[1];
                  r_data1 <= w_a;
                  r_data2 <= w_b;
                  r_cnt   <= 4'(SETTLE_CYC - 1);
                  if (w_div_zero) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_id    <= w_grant[1];
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b1;
                     r_state     <= ST_RESP;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_id    <= r_id;
                  r_rsp_data  <= RES_W'(sel_result(r_op, calc.add, calc.sub, calc.mul, calc.div));
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign calc.data1  = r_data1;
   assign calc.data2  = r_data2;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_err   = r_rsp_err;

endmodule
